// File: rtl/bin2bcd_seq_ctrl_if.sv
// rtl/bin2bcd_seq_ctrl_if.sv - start/done handshake and result bus of the sequential binary-to-BCD converter
interface bin2bcd_seq_ctrl_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);
  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic                  ready;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;

  modport master (
    output start,
    output bin,
    input  ready,
    input  busy,
    input  done,
    input  bcd
  );

  modport slave (
    input  start,
    input  bin,
    output ready,
    output busy,
    output done,
    output bcd
  );
endinterface

// File: rtl/bin2bcd_seq_ctrl.sv
// rtl/bin2bcd_seq_ctrl.sv - sequential shift-and-add3 binary-to-BCD converter with start/done handshake
module bin2bcd_seq_ctrl #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5,
  parameter int CNT_W  = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  bin2bcd_seq_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     shift_q, shift_d;
  logic [4*DIGITS-1:0]  scratch_q, scratch_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [4*DIGITS-1:0]  bcd_q, bcd_d;

  logic [4*DIGITS-1:0]  adj;
  logic [4*DIGITS-1:0]  scratch_shifted;

  // One row of add3_ge5 cells; a nibble <= 9 plus 3 stays within 4 bits.
  always_comb begin
    adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end else begin
        adj[4*i +: 4] = scratch_q[4*i +: 4];
      end
    end
  end

  // Top bit of the adjusted scratch falls off: carries out of the MSD are discarded.
  assign scratch_shifted = {adj[4*DIGITS-2:0], shift_q[WIDTH-1]};

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          shift_d   = bus.bin;
          scratch_d = '0;
          cnt_d     = '0;
          state_d   = CONV;
        end
      end
      CONV: begin
        scratch_d = scratch_shifted;
        shift_d   = {shift_q[WIDTH-2:0], 1'b0};
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          bcd_d   = scratch_shifted;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
    end
  end

  assign bus.ready = (state_q == IDLE);
  assign bus.busy  = (state_q == CONV);
  assign bus.done  = (state_q == DONE);
  assign bus.bcd   = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq_ctrl.sv
// tb/tb_bin2bcd_seq_ctrl.sv - directed bench for bin2bcd_seq_ctrl at 16-bit/5-digit and 8-bit/3-digit sizes
module tb_bin2bcd_seq_ctrl;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  bin2bcd_seq_ctrl_if #(.WIDTH(16), .DIGITS(5)) b16 ();
  bin2bcd_seq_ctrl_if #(.WIDTH(8),  .DIGITS(3)) b8  ();

  bin2bcd_seq_ctrl #(.WIDTH(16), .DIGITS(5), .CNT_W(6)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b16)
  );

  bin2bcd_seq_ctrl #(.WIDTH(8), .DIGITS(3), .CNT_W(4)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start one 16-bit conversion and wait (bounded) for done; checks latency, result and return to IDLE.
  task automatic convert16(input logic [15:0] v, input logic [19:0] exp, input string tag);
    int n;
    b16.bin   = v;
    b16.start = 1'b1;
    tick();
    b16.start = 1'b0;
    n = 0;
    while (!b16.done && n < 40) begin
      tick();
      n++;
    end
    check({tag, " latency"}, n, 16);
    check({tag, " bcd"}, {12'd0, b16.bcd}, {12'd0, exp});
    tick();
    check({tag, " ready after"}, {31'd0, b16.ready}, 1);
    check({tag, " done one cycle"}, {31'd0, b16.done}, 0);
  endtask

  initial begin
    int t_first, t_second, low_a, low_b, n;
    logic [19:0] r_first, r_second;
    logic [11:0] exp8;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    b16.start = 1'b0; b16.bin = '0;
    b8.start  = 1'b0; b8.bin  = '0;
    #12;
    check("rst ready", {31'd0, b16.ready}, 1);
    check("rst busy",  {31'd0, b16.busy},  0);
    check("rst done",  {31'd0, b16.done},  0);
    check("rst bcd",   {12'd0, b16.bcd},   0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 255: also look at busy/ready during CONV
    b16.bin = 16'd255; b16.start = 1'b1;
    tick();
    b16.start = 1'b0;
    check("255 busy", {31'd0, b16.busy}, 1);
    check("255 ready low", {31'd0, b16.ready}, 0);
    for (int i = 0; i < 15; i++) tick();
    check("255 no early done", {31'd0, b16.done}, 0);
    tick();
    check("255 done", {31'd0, b16.done}, 1);
    check("255 bcd", {12'd0, b16.bcd}, 32'h00255);
    tick();
    check("255 ready again", {31'd0, b16.ready}, 1);
    check("255 bcd held", {12'd0, b16.bcd}, 32'h00255);

    convert16(16'd65535, 20'h65535, "max");
    convert16(16'd0,     20'h00000, "zero");
    convert16(16'd9999,  20'h09999, "9999");

    // start held high: back-to-back conversions, bin resampled in IDLE
    b16.bin = 16'd1234; b16.start = 1'b1;
    tick();
    b16.bin = 16'd4321;
    t_first = -1; t_second = -1; low_a = 0; low_b = 0;
    r_first = '0; r_second = '0;
    for (int t = 0; t < 36; t++) begin
      if (t > 0) tick();
      if (b16.done) begin
        if (t_first < 0) begin t_first = t; r_first = b16.bcd; end
        else begin t_second = t; r_second = b16.bcd; end
      end
      if (!b16.ready) begin
        if (t < 18) low_a++; else low_b++;
      end
    end
    b16.start = 1'b0;
    check("b2b first done", t_first, 16);
    check("b2b spacing", t_second - t_first, 18);
    check("b2b bcd1", {12'd0, r_first}, 32'h01234);
    check("b2b bcd2", {12'd0, r_second}, 32'h04321);
    check("b2b ready low 1", low_a, 17);
    check("b2b ready low 2", low_b, 17);
    tick();
    check("b2b stop", {31'd0, b16.ready}, 1);

    // start and bin disturbed during CONV are ignored
    b16.bin = 16'd42; b16.start = 1'b1;
    tick();
    b16.start = 1'b0;
    tick(); tick(); tick();
    b16.bin = 16'd9999; b16.start = 1'b1;
    tick();
    b16.start = 1'b0;
    n = 4;
    while (!b16.done && n < 40) begin tick(); n++; end
    check("ign latency", n, 16);
    check("ign bcd", {12'd0, b16.bcd}, 32'h00042);
    tick();
    tick();
    check("ign not queued", {31'd0, b16.ready}, 1);

    // reset in the middle of converting 50000
    b16.bin = 16'd50000; b16.start = 1'b1;
    tick();
    b16.start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("pre-rst bcd", {12'd0, b16.bcd}, 32'h00042);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst bcd",   {12'd0, b16.bcd}, 0);
    check("async rst ready", {31'd0, b16.ready}, 1);
    check("async rst busy",  {31'd0, b16.busy}, 0);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (b16.done) n++;
    end
    check("rst no done", n, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    convert16(16'd50000, 20'h50000, "after rst");

    // exhaustive 8-bit instance against a decimal-digit model
    for (int v = 0; v < 256; v++) begin
      exp8 = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
      b8.bin = 8'(v); b8.start = 1'b1;
      tick();
      b8.start = 1'b0;
      n = 0;
      while (!b8.done && n < 20) begin tick(); n++; end
      check($sformatf("w8 latency %0d", v), n, 8);
      check($sformatf("w8 bcd %0d", v), {20'd0, b8.bcd}, {20'd0, exp8});
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
